// File: rtl/spi_rx_serf.sv
// SPI serf receiver: synchronizes SS_n/SCLK/MOSI to clk and reassembles 8/16-bit frames.
// A good frame updates rx_data with a rdy pulse; a wrong bit count gives a frame_err pulse.
module spi_rx_serf #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        pos_edge,
    input  logic        width8,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        frame_err
);

    typedef enum logic {StIdle, StRx} state_t;

    logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_ss_hist, r_sclk_hist;
    state_t                 r_state, w_state_d;
    logic                   r_mode_pos, r_mode_w8;
    logic [4:0]             r_bit_cnt;
    logic [15:0]            r_shreg;
    logic [15:0]            r_rx_data;
    logic                   r_good_q, r_bad_q, r_rdy, r_frame_err;

    logic w_ss, w_sclk, w_mosi;
    logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_sample;
    logic w_start, w_shift, w_end, w_cnt_ok, w_good, w_bad;

    // Chains reset low, so a frame already running at reset release never shows a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_hist   <= 1'b0;
            r_sclk_hist <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_hist   <= w_ss;
            r_sclk_hist <= w_sclk;
        end
    end

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall   = r_ss_hist & ~w_ss;
    assign w_ss_rise   = ~r_ss_hist & w_ss;
    assign w_sclk_rise = ~r_sclk_hist & w_sclk;
    assign w_sclk_fall = r_sclk_hist & ~w_sclk;
    assign w_sample    = r_mode_pos ? w_sclk_fall : w_sclk_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_ss_fall) w_state_d = StRx;
            StRx:   if (w_ss_rise) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // A sample edge coinciding with the end of frame is dropped.
    always_comb begin
        w_start  = (r_state == StIdle) & w_ss_fall;
        w_shift  = (r_state == StRx) & w_sample & ~w_ss_rise;
        w_end    = (r_state == StRx) & w_ss_rise;
        w_cnt_ok = (r_bit_cnt == (r_mode_w8 ? 5'd8 : 5'd16));
        w_good   = w_end & w_cnt_ok;
        w_bad    = w_end & ~w_cnt_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_pos  <= 1'b0;
            r_mode_w8   <= 1'b0;
            r_bit_cnt   <= 5'd0;
            r_shreg     <= 16'h0000;
            r_rx_data   <= 16'h0000;
            r_good_q    <= 1'b0;
            r_bad_q     <= 1'b0;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode_pos <= pos_edge;
                r_mode_w8  <= width8;
                r_bit_cnt  <= 5'd0;
                r_shreg    <= 16'h0000;
            end else if (w_shift) begin
                r_shreg   <= {r_shreg[14:0], w_mosi};
                r_bit_cnt <= (r_bit_cnt == 5'd31) ? r_bit_cnt : r_bit_cnt + 5'd1;
            end
            if (w_good) r_rx_data <= r_mode_w8 ? {8'h00, r_shreg[7:0]} : r_shreg;
            r_good_q    <= w_good;
            r_bad_q     <= w_bad;
            r_rdy       <= r_good_q;
            r_frame_err <= r_bad_q;
        end
    end

    assign rx_data   = r_rx_data;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_rx_serf.sv
// Bench for spi_rx_serf: master-timed SPI frames (SCLK = clk/32) checked against a
// frame-level model of bit count, width and last-good-data.
module tb_spi_rx_serf;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        pos_edge = 1'b0;
    logic        width8 = 1'b0;
    logic [15:0] rx_data;
    logic        rdy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    int n_rdy = 0;
    int n_err = 0;
    bit width_bad = 1'b0;
    bit overlap_bad = 1'b0;
    logic prev_rdy = 1'b0;
    logic prev_err = 1'b0;

    logic [15:0] model_rx = 16'h0000;

    spi_rx_serf #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .pos_edge (pos_edge),
        .width8   (width8),
        .rx_data  (rx_data),
        .rdy      (rdy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts strobes, flags multi-cycle or simultaneous strobes.
    always @(negedge clk) begin
        if (rdy === 1'b1) n_rdy++;
        if (frame_err === 1'b1) n_err++;
        if ((rdy === 1'b1 && prev_rdy === 1'b1) || (frame_err === 1'b1 && prev_err === 1'b1))
            width_bad = 1'b1;
        if (rdy === 1'b1 && frame_err === 1'b1) overlap_bad = 1'b1;
        prev_rdy = rdy;
        prev_err = frame_err;
    end

    // Expected outcome of a frame from its bit count and the width latched at SS_n fall.
    task automatic model_frame(input logic [31:0] bits, input int nbits, input bit w8,
                               output bit exp_ok);
        int cnt;
        int need;
        cnt    = (nbits > 31) ? 31 : nbits;
        need   = w8 ? 8 : 16;
        exp_ok = (cnt == need);
        if (exp_ok) model_rx = 16'(bits % (32'd1 << need));
    endtask

    // Master-timed frame, nbits LSBs of bits sent MSB first. Optional width8 flip
    // before bit toggle_at and reset pulse before bit reset_at (-1 disables).
    task automatic run_frame(input logic [31:0] bits, input int nbits, input bit pos,
                             input bit w8, input int toggle_at, input int reset_at,
                             output int lat);
        @(negedge clk);
        n_rdy    = 0;
        n_err    = 0;
        pos_edge = pos;
        width8   = w8;
        SS_n     = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            if (i == toggle_at) width8 = ~width8;
            if (pos) begin
                SCLK = 1'b1;
                MOSI = bits[nbits-1-i];
                repeat (HALF) @(negedge clk);
                SCLK = 1'b0;
                repeat (HALF) @(negedge clk);
            end else begin
                MOSI = bits[nbits-1-i];
                repeat (HALF) @(negedge clk);
                SCLK = 1'b1;
                repeat (HALF) @(negedge clk);
                SCLK = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        SS_n = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1 || frame_err === 1'b1) begin
                lat = k;
                break;
            end
        end
        repeat (SYNC_STAGES + 10) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rx_data got %h exp 0000", rx_data);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy got %b exp 0", rdy);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_err got %b exp 0", frame_err);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic16;
        int lat;
        bit ok;
        run_frame(32'h0000A5C3, 16, 1'b0, 1'b0, -1, -1, lat);
        model_frame(32'h0000A5C3, 16, 1'b0, ok);
        checks++;
        if (n_rdy !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL basic16_pulses got rdy=%0d err=%0d exp rdy=1 err=0", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'hA5C3) begin
            errors++;
            $display("FAIL basic16_data got %h exp a5c3", rx_data);
        end
        checks++;
        if (lat !== SYNC_STAGES + 2) begin
            errors++;
            $display("FAIL basic16_latency got %0d exp %0d", lat, SYNC_STAGES + 2);
        end
    endtask

    task automatic test_short;
        int lat;
        bit ok;
        run_frame(32'h00000ABC, 12, 1'b0, 1'b0, -1, -1, lat);
        model_frame(32'h00000ABC, 12, 1'b0, ok);
        checks++;
        if (n_rdy !== 0 || n_err !== 1) begin
            errors++;
            $display("FAIL short_pulses got rdy=%0d err=%0d exp rdy=0 err=1", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'hA5C3) begin
            errors++;
            $display("FAIL short_data_kept got %h exp a5c3", rx_data);
        end
        checks++;
        if (lat !== SYNC_STAGES + 2) begin
            errors++;
            $display("FAIL short_latency got %0d exp %0d", lat, SYNC_STAGES + 2);
        end
    endtask

    task automatic test_basic8;
        int lat;
        bit ok;
        logic [31:0] tx;
        tx = {16'h0000, 8'($urandom), 8'h96};
        run_frame(tx, 8, 1'b1, 1'b1, -1, -1, lat);
        model_frame(tx, 8, 1'b1, ok);
        checks++;
        if (n_rdy !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL basic8_pulses got rdy=%0d err=%0d exp rdy=1 err=0", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'h0096) begin
            errors++;
            $display("FAIL basic8_data got %h exp 0096", rx_data);
        end
    endtask

    task automatic test_long;
        int lat;
        bit ok;
        run_frame(32'h0000013C, 9, 1'b0, 1'b1, -1, -1, lat);
        model_frame(32'h0000013C, 9, 1'b1, ok);
        checks++;
        if (n_rdy !== 0 || n_err !== 1) begin
            errors++;
            $display("FAIL long_pulses got rdy=%0d err=%0d exp rdy=0 err=1", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'h0096) begin
            errors++;
            $display("FAIL long_data_kept got %h exp 0096", rx_data);
        end
        run_frame(32'h0000003C, 8, 1'b0, 1'b1, -1, -1, lat);
        model_frame(32'h0000003C, 8, 1'b1, ok);
        checks++;
        if (n_rdy !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL long_next_pulses got rdy=%0d err=%0d exp rdy=1 err=0", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'h003C) begin
            errors++;
            $display("FAIL long_next_data got %h exp 003c", rx_data);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit ok;
        run_frame(32'h0000BEEF, 16, 1'b0, 1'b0, -1, 5, lat);
        model_rx = 16'h0000;
        checks++;
        if (n_rdy !== 0 || n_err !== 0) begin
            errors++;
            $display("FAIL rstmid_pulses got rdy=%0d err=%0d exp 0 0", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== model_rx) begin
            errors++;
            $display("FAIL rstmid_data got %h exp %h", rx_data, model_rx);
        end
        run_frame(32'h00001234, 16, 1'b0, 1'b0, -1, -1, lat);
        model_frame(32'h00001234, 16, 1'b0, ok);
        checks++;
        if (n_rdy !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL rstmid_next_pulses got rdy=%0d err=%0d exp 1 0", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'h1234) begin
            errors++;
            $display("FAIL rstmid_next_data got %h exp 1234", rx_data);
        end
    endtask

    task automatic test_mode_toggle;
        int lat;
        bit ok;
        run_frame(32'h0000FFFF, 16, 1'b0, 1'b0, 4, -1, lat);
        model_frame(32'h0000FFFF, 16, 1'b0, ok);
        width8 = 1'b0;
        checks++;
        if (n_rdy !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL toggle_pulses got rdy=%0d err=%0d exp 1 0", n_rdy, n_err);
        end
        checks++;
        if (rx_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL toggle_data got %h exp ffff", rx_data);
        end
    endtask

    task automatic test_random;
        int lat;
        int nbits;
        int need;
        bit ok;
        bit pos;
        bit w8;
        logic [31:0] tx;
        for (int it = 0; it < 10; it++) begin
            pos  = 1'($urandom_range(0, 1));
            w8   = 1'($urandom_range(0, 1));
            tx   = $urandom;
            need = w8 ? 8 : 16;
            case ($urandom_range(0, 3))
                0:       nbits = need;
                1:       nbits = need - 1;
                2:       nbits = need + 1;
                default: nbits = int'($urandom_range(1, 20));
            endcase
            run_frame(tx, nbits, pos, w8, -1, -1, lat);
            model_frame(tx, nbits, w8, ok);
            checks++;
            if (n_rdy !== (ok ? 1 : 0) || n_err !== (ok ? 0 : 1)) begin
                errors++;
                $display("FAIL rand%0d_pulses got rdy=%0d err=%0d exp ok=%0d (n=%0d w8=%0d)",
                         it, n_rdy, n_err, ok, nbits, w8);
            end
            checks++;
            if (rx_data !== model_rx) begin
                errors++;
                $display("FAIL rand%0d_data got %h exp %h", it, rx_data, model_rx);
            end
            checks++;
            if (lat !== SYNC_STAGES + 2) begin
                errors++;
                $display("FAIL rand%0d_latency got %0d exp %0d", it, lat, SYNC_STAGES + 2);
            end
        end
    endtask

    task automatic test_pulse_shape;
        checks++;
        if (width_bad !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width got multi-cycle strobe exp single-cycle");
        end
        checks++;
        if (overlap_bad !== 1'b0) begin
            errors++;
            $display("FAIL pulse_overlap got rdy&frame_err together exp never");
        end
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_short();
        test_basic8();
        test_long();
        test_reset_mid();
        test_mode_toggle();
        test_random();
        test_pulse_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
